// File: rtl/led_display_mode_sequencer.sv
// Playlist sequencer for led_display_pattern_gen: picks mode/colour from buttons or a dwell timer
// and defers every mode change to a frame boundary so a frame never mixes two patterns.
module led_display_mode_sequencer #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter bit SIMULATION   = 1'b0,
    parameter int DWELL_CYCLES = 500_000_000,
    parameter int PEND_TIMEOUT = 65_536
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       btn_next_in,
    input  logic       btn_prev_in,
    input  logic       auto_en_in,
    input  logic [2:0] colour_sw_in,
    input  logic       row_valid_in,
    input  logic [3:0] row_address_in,
    output logic [3:0] mode_out,
    output logic [2:0] colour_out,
    output logic [2:0] step_out,
    output logic       mode_change_out
);

    // A DWELL_CYCLES of 0 falls back to a 5 s dwell derived from the clock frequency.
    localparam int DWELL_BASE  = (DWELL_CYCLES > 0) ? DWELL_CYCLES : 5 * SYS_CLK_FREQ;
    localparam int DWELL_EFF   = SIMULATION ? 2000 : DWELL_BASE;
    localparam int TIMEOUT_EFF = SIMULATION ? 256 : PEND_TIMEOUT;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_EFF - 1);
    localparam logic [31:0] PEND_LAST  = 32'(TIMEOUT_EFF - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  step_reg, step_next;
    logic [2:0]  target_reg, target_next;
    logic [3:0]  mode_reg, mode_next;
    logic [2:0]  colour_reg, colour_next;
    logic [2:0]  auto_colour_reg, auto_colour_next;
    logic [31:0] dwell_reg, dwell_next;
    logic [31:0] pend_timer_reg, pend_timer_next;

    logic frame_boundary;
    logic btn_any;
    logic dwell_expire;
    logic req_fwd;
    logic req_back;

    function automatic logic [2:0] step_inc(input logic [2:0] s);
        return (s == 3'd4) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] step_dec(input logic [2:0] s);
        return (s == 3'd0) ? 3'd4 : s - 3'd1;
    endfunction

    function automatic logic [3:0] playlist(input logic [2:0] s);
        logic [3:0] m;
        case (s)
            3'd1:    m = 4'd1;
            3'd2:    m = 4'd7;
            3'd3:    m = 4'd8;
            3'd4:    m = 4'd9;
            default: m = 4'd0;
        endcase
        return m;
    endfunction

    assign frame_boundary = row_valid_in && (row_address_in == 4'hF);
    assign btn_any        = btn_next_in | btn_prev_in;
    // Any button activity (even a cancelled next+prev pair) discards a coincident dwell expiry.
    assign dwell_expire   = (state_reg == ST_RUN) && auto_en_in && (dwell_reg == DWELL_LAST) && !btn_any;
    assign req_fwd        = (btn_next_in & ~btn_prev_in) | dwell_expire;
    assign req_back       = btn_prev_in & ~btn_next_in;

    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        target_next      = target_reg;
        mode_next        = mode_reg;
        auto_colour_next = auto_colour_reg;
        dwell_next       = 32'd0;
        pend_timer_next  = 32'd0;
        case (state_reg)
            ST_RUN: begin
                if (req_fwd) begin
                    target_next = step_inc(step_reg);
                    state_next  = ST_PEND;
                end else if (req_back) begin
                    target_next = step_dec(step_reg);
                    state_next  = ST_PEND;
                end else if (auto_en_in) begin
                    dwell_next = dwell_reg + 32'd1;
                end
            end
            ST_PEND: begin
                pend_timer_next = pend_timer_reg + 32'd1;
                if (req_fwd) begin
                    target_next = step_inc(target_reg);
                end else if (req_back) begin
                    target_next = step_dec(target_reg);
                end
                if (frame_boundary || (pend_timer_reg == PEND_LAST)) begin
                    pend_timer_next = 32'd0;
                    if (target_next != step_reg) begin
                        state_next = ST_APPLY;
                        step_next  = target_next;
                        mode_next  = playlist(target_next);
                        // Auto colour advances once per full playlist lap, skipping 0 (black).
                        if (auto_en_in && (step_reg == 3'd4) && (target_next == 3'd0)) begin
                            auto_colour_next = (auto_colour_reg == 3'd7) ? 3'd1 : auto_colour_reg + 3'd1;
                        end
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_APPLY: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        colour_next = auto_en_in ? auto_colour_next : colour_sw_in;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg       <= ST_RUN;
            step_reg        <= 3'd0;
            target_reg      <= 3'd0;
            mode_reg        <= 4'd0;
            colour_reg      <= 3'b001;
            auto_colour_reg <= 3'b001;
            dwell_reg       <= 32'd0;
            pend_timer_reg  <= 32'd0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            target_reg      <= target_next;
            mode_reg        <= mode_next;
            colour_reg      <= colour_next;
            auto_colour_reg <= auto_colour_next;
            dwell_reg       <= dwell_next;
            pend_timer_reg  <= pend_timer_next;
        end
    end

    assign mode_out        = mode_reg;
    assign colour_out      = colour_reg;
    assign step_out        = step_reg;
    assign mode_change_out = (state_reg == ST_APPLY);

endmodule

// File: tb/tb_led_display_mode_sequencer.sv
// Scoreboard bench for led_display_mode_sequencer: stimulus pushes expected applies,
// a negedge monitor pops and compares on every mode_change_out pulse.
module tb_led_display_mode_sequencer;

    logic       clk_in;
    logic       reset_in;
    logic       btn_next_in;
    logic       btn_prev_in;
    logic       auto_en_in;
    logic [2:0] colour_sw_in;
    logic       row_valid_in;
    logic [3:0] row_address_in;
    logic [3:0] mode_out;
    logic [2:0] colour_out;
    logic [2:0] step_out;
    logic       mode_change_out;

    led_display_mode_sequencer #(
        .SYS_CLK_FREQ(100_000_000),
        .SIMULATION  (1'b1),
        .DWELL_CYCLES(500_000_000),
        .PEND_TIMEOUT(65_536)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .btn_next_in    (btn_next_in),
        .btn_prev_in    (btn_prev_in),
        .auto_en_in     (auto_en_in),
        .colour_sw_in   (colour_sw_in),
        .row_valid_in   (row_valid_in),
        .row_address_in (row_address_in),
        .mode_out       (mode_out),
        .colour_out     (colour_out),
        .step_out       (step_out),
        .mode_change_out(mode_change_out)
    );

    typedef struct {
        logic [2:0] step;
        logic [3:0] mode;
        logic [2:0] colour;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic push_exp(input logic [2:0] s, input logic [3:0] m, input logic [2:0] c);
        exp_t e;
        e.step = s; e.mode = m; e.colour = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every applied mode change must match the oldest expectation.
    always @(negedge clk_in) begin
        if (!reset_in && mode_change_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got step=%0d mode=%0d, expected no mode change", step_out, mode_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (step_out == e.step && mode_out == e.mode && colour_out == e.colour) begin
                    n_pass++;
                    $display("apply: step=%0d mode=%0d colour=%03b", step_out, mode_out, colour_out);
                end else begin
                    $display("FAIL apply: got step=%0d mode=%0d colour=%03b, expected step=%0d mode=%0d colour=%03b",
                             step_out, mode_out, colour_out, e.step, e.mode, e.colour);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        repeat (3) tick();
        reset_in = 1'b0;
    endtask

    task automatic pulse_next();
        btn_next_in = 1'b1;
        tick();
        btn_next_in = 1'b0;
    endtask

    task automatic pulse_prev();
        btn_prev_in = 1'b1;
        tick();
        btn_prev_in = 1'b0;
    endtask

    task automatic frame_end();
        row_valid_in   = 1'b1;
        row_address_in = 4'hF;
        tick();
        row_valid_in   = 1'b0;
        row_address_in = 4'h0;
    endtask

    // n cycles with mode_out fixed and no pulse, recorded as one comparison.
    task automatic stable(input string name, input int n, input logic [3:0] m);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (mode_out != m || mode_change_out) bad++;
            tick();
        end
        chk(name, bad, 0);
    endtask

    task automatic wait_pulse(input int bound, output int lat);
        logic found = 1'b0;
        lat = 0;
        while (!found && lat < bound) begin
            @(negedge clk_in);
            lat++;
            if (mode_change_out) found = 1'b1;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        int got;
        int t1;
        int t2;
        logic [2:0] col;
        logic [2:0] s;
        logic [3:0] playlist_mode [5];

        playlist_mode[0] = 4'd0; playlist_mode[1] = 4'd1; playlist_mode[2] = 4'd7;
        playlist_mode[3] = 4'd8; playlist_mode[4] = 4'd9;

        reset_in = 1'b1; btn_next_in = 1'b0; btn_prev_in = 1'b0; auto_en_in = 1'b0;
        colour_sw_in = 3'b111; row_valid_in = 1'b0; row_address_in = 4'h0;

        // Reset values while reset is held.
        repeat (3) tick();
        @(negedge clk_in);
        chk("reset_mode", int'(mode_out), 0);
        chk("reset_colour", int'(colour_out), 1);
        chk("reset_step", int'(step_out), 0);
        chk("reset_pulse", int'(mode_change_out), 0);
        tick();
        reset_in = 1'b0;
        colour_sw_in = 3'b001;
        tick();

        // Next pulse held until a frame boundary 10 cycles later.
        pulse_next();
        stable("no_change_before_fb", 10, 4'd0);
        push_exp(3'd1, 4'd1, 3'b001);
        frame_end();
        @(negedge clk_in);
        chk("fb_latency_pulse", int'(mode_change_out), 1);
        chk("fb_latency_mode", int'(mode_out), 1);
        tick();
        stable("single_pulse", 5, 4'd1);

        // Prev from step 0 wraps to 4; then two nexts while pending.
        do_reset();
        pulse_prev();
        push_exp(3'd4, 4'd9, 3'b001);
        frame_end();
        repeat (3) tick();
        pulse_next(); pulse_next();
        push_exp(3'd1, 4'd1, 3'b001);
        frame_end();
        repeat (3) tick();
        pulse_next(); pulse_next();
        push_exp(3'd3, 4'd8, 3'b001);
        frame_end();
        repeat (3) tick();
        chk("double_next_step", int'(step_out), 3);

        // Simultaneous next+prev cancels.
        btn_next_in = 1'b1; btn_prev_in = 1'b1;
        tick();
        btn_next_in = 1'b0; btn_prev_in = 1'b0;
        stable("both_buttons_100", 100, 4'd8);
        frame_end();
        stable("both_buttons_fb", 20, 4'd8);
        chk("both_buttons_step", int'(step_out), 3);

        // Manual colour follows the switches one cycle later.
        colour_sw_in = 3'b110;
        tick();
        @(negedge clk_in);
        chk("colour_sw_110", int'(colour_out), 6);
        tick();
        colour_sw_in = 3'b001;
        tick();
        @(negedge clk_in);
        chk("colour_sw_001", int'(colour_out), 1);
        tick();

        // No frame boundary: forced apply after 256 pending cycles.
        pulse_next();
        push_exp(3'd4, 4'd9, 3'b001);
        wait_pulse(400, lat);
        chk("pend_timeout_latency", lat, 257);
        repeat (2) tick();

        // Reset during PEND discards the target.
        do_reset();
        pulse_next();
        push_exp(3'd1, 4'd1, 3'b001);
        frame_end();
        repeat (2) tick();
        pulse_next();
        repeat (5) tick();
        do_reset();
        stable("reset_in_pend", 300, 4'd0);
        chk("reset_in_pend_step", int'(step_out), 0);

        // Auto mode: 35 dwell steps (7 laps), FB every 64 cycles.
        do_reset();
        col = 3'b001;
        for (int i = 1; i <= 35; i++) begin
            s = 3'(i % 5);
            if (s == 3'd0) col = (col == 3'd7) ? 3'd1 : col + 3'd1;
            push_exp(s, playlist_mode[s], col);
        end
        auto_en_in = 1'b1;
        cyc = 0; got = 0; t1 = 0; t2 = 0;
        while (got < 35 && cyc < 76000) begin
            row_valid_in   = (cyc % 64 == 63);
            row_address_in = row_valid_in ? 4'hF : 4'h0;
            @(negedge clk_in);
            if (mode_change_out) begin
                got++;
                if (got == 1) t1 = cyc;
                if (got == 2) t2 = cyc;
                if (got == 5) chk("first_wrap_colour", int'(colour_out), 2);
            end
            tick();
            cyc++;
        end
        row_valid_in = 1'b0; row_address_in = 4'h0;
        chk("auto_step_count", got, 35);
        chk_range("dwell_interval", t2 - t1, 2002, 2065);
        @(negedge clk_in);
        chk("seventh_wrap_colour", int'(colour_out), 1);
        tick();
        auto_en_in = 1'b0;
        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
